dem_switch_tree: RTL and testbench
==================================

// Module: dem_switch_tree
// PURPOSE
//  Parametrised tree-structured DEM scrambler for the unit-element DAC. NUM_LAYERS layers of 2-way switching nodes
//  split one signed sample into 2**NUM_LAYERS leaf codes whose sum equals the (clipped) input.
//  Streaming valid pipeline with one register stage per layer and per-node first-order shaping state.
//  Sits between the modulator output and the DAC element drivers.
// PARAMETERS
//  INPUT_WIDTH  8  signed sample / node / leaf width; must be >= NUM_LAYERS+2
//  NUM_LAYERS   3  tree depth, 1..6; leaf count NUM_OUT = 2**NUM_LAYERS
//  LFSR_SEED    16'hACE1  nonzero seed for the optional dither LFSR
// PORTS
//  clk_i         in   1                      clock
//  reset_i       in   1                      reset, asynchronous, active-high
//  clear_i       in   1                      sync clear: shaping states and pipeline valids
//  valid_i       in   1                      x_in_i is valid this cycle
//  x_in_i        in   INPUT_WIDTH            signed input sample
//  valid_o       out  1                      x_out_o valid
//  x_out_o       out  NUM_OUT*INPUT_WIDTH    leaf k at [k*INPUT_WIDTH +: INPUT_WIDTH], signed
//  layer_valid_o out  NUM_LAYERS             bit n = stage n+1 register holds a valid sample
//  sat_o         out  1                      sample on valid_o was clipped at input
//  zero_o        out  1                      all leaves of sample on valid_o are 0
//  sample_cnt_o  out  16                     count of valid_o pulses, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0, all node toggle states 0, all stage valids 0, LFSR = LFSR_SEED.
//  - Input clip: MAX = 2**NUM_LAYERS; x < -MAX -> -MAX, x > MAX -> MAX, sat flag set; flag travels with sample.
//  - Node: input x, toggle bit t. x odd: s = t ? -1 : +1, t <= ~t. x even: s = 0, t unchanged.
//    out1 = (x+s)>>>1, out2 = (x-s)>>>1; computed in INPUT_WIDTH+1 bits, exact (x+s even). out1+out2 == x.
//  - Node at layer n, index i feeds layer n+1 nodes 2i (from out1) and 2i+1 (from out2); leaves = layer NUM_LAYERS outs.
//  - Stage n register loads and node state updates only when stage n-1 valid is 1; bubbles propagate, hold state.
//  - Latency: sample with valid_i in cycle c appears with valid_o in cycle c+NUM_LAYERS; throughput 1 sample/cycle.
//  - x_out_o holds last valid value while valid_o = 0.
//  - sat_o, zero_o aligned with valid_o; 0 when valid_o = 0.
//  - sample_cnt_o increments on each valid_o cycle.
//  - clear_i: next edge zeroes all toggle bits and stage valids (in-flight samples dropped), reloads LFSR;
//    clear_i with valid_i in same cycle: clear wins, sample dropped.
//    x_out_o and sample_cnt_o not cleared by clear_i.
//  - reset_i mid-stream: immediate return to reset values; no partial sample emitted after release.
//  - Invariant: for every valid_o, sum of leaves == clipped input; each leaf in [-1, +1] when |x| <= MAX.
// CONFIGURATION
//  DEM_SWITCH_DITHER_EN defined:
//    - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every valid_i cycle.
//    - Node at layer n, index i uses s sign from t XOR lfsr[(n*7+i) % 16] on odd x.
//    - t still toggles as above; sum invariant preserved.
//  DEM_SWITCH_DITHER_EN undefined:
//    - no LFSR; pure alternating sign per node as above; LFSR_SEED unused.
// TESTING
//  1. Reset, then valid_i=1 x=5 once (defaults) -> valid_o 3 cycles later; leaves {1,1,1,0,1,0,1,0} (leaf0 first).
//     sat_o=0, zero_o=0, sample_cnt_o=1.
//  2. x=5 two consecutive cycles -> layer-1 split (3,2) then (2,3); both leaf sums == 5.
//  3. x=20 then x=-20 -> clipped to 8 and -8; leaves all +1 then all -1; sat_o=1 on both outputs.
//  4. x=0 -> all leaves 0, zero_o=1.
//     valid_i gaps (1,0,1) -> valid_o pattern 1,0,1 delayed by 3; node states unchanged across bubble.
//  5. clear_i asserted with valid_i=1 while 2 samples in flight -> no valid_o for any of the 3.
//     Next x=5 reproduces test-1 leaves.
//  6. Random x in [-8,8], 10k samples, both macro settings -> every leaf sum == input.
//     Per-node running sum of s stays in {-1,0,+1} without macro.

Source files
------------

// File: rtl/dem_switch_tree.sv
`default_nettype none
// ============================================================================
// Module   : dem_switch_tree
// Purpose  : Tree-structured dynamic element matching scrambler. NUM_LAYERS
//            layers of 2-way switching nodes split one clipped signed sample
//            into NUM_OUT = 2**NUM_LAYERS leaf codes whose sum equals the
//            clipped input. One register stage per layer; every node keeps
//            a one-bit first-order shaping (toggle) state.
// Ports    : clk_i          clock
//            reset_i        asynchronous active-high reset
//            clear_i        synchronous clear of toggles, stage valids, LFSR
//            valid_i/x_in_i input sample strobe / signed sample
//            valid_o        leaf vector valid
//            x_out_o        leaf k at [k*INPUT_WIDTH +: INPUT_WIDTH], signed
//            layer_valid_o  bit n = stage n+1 holds a valid sample
//            sat_o          sample on valid_o was clipped at input
//            zero_o         all leaves of the sample on valid_o are zero
//            sample_cnt_o   running count of valid_o pulses (wraps)
// Options  : DEM_SWITCH_DITHER_EN - XOR node signs with a 16-bit LFSR
// Revision : 1.0 - initial release
// ============================================================================
module dem_switch_tree #(
    parameter int          INPUT_WIDTH = 8,
    parameter int          NUM_LAYERS  = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  clear_i,
    input  logic                                  valid_i,
    input  logic [INPUT_WIDTH-1:0]                x_in_i,
    output logic                                  valid_o,
    output logic [(2**NUM_LAYERS)*INPUT_WIDTH-1:0] x_out_o,
    output logic [NUM_LAYERS-1:0]                 layer_valid_o,
    output logic                                  sat_o,
    output logic                                  zero_o,
    output logic [15:0]                           sample_cnt_o
);

    localparam int NUM_OUT  = 2**NUM_LAYERS;
    localparam int NUM_NODE = NUM_OUT / 2;
    localparam int W        = INPUT_WIDTH;

    localparam logic signed [W-1:0] c_MAX = W'(NUM_OUT);
    localparam logic signed [W-1:0] c_MIN = -c_MAX;

    // stage_q[n][k] : output k of layer n (only k < 2**n is meaningful)
    logic [W-1:0] stage_q   [1:NUM_LAYERS][NUM_OUT];
    logic [W-1:0] stage_d   [1:NUM_LAYERS][NUM_OUT];
    logic [W-1:0] w_node_in [1:NUM_LAYERS][NUM_NODE];
    logic         tog_q     [1:NUM_LAYERS][NUM_NODE];
    logic         tog_d     [1:NUM_LAYERS][NUM_NODE];

    logic [NUM_LAYERS:1] valid_q;
    logic [NUM_LAYERS:1] sat_q;
    logic [NUM_LAYERS:1] w_en;
    logic [NUM_LAYERS:1] w_sat_in;
    logic [15:0]         cnt_q;
    logic [W-1:0]        w_x_clip;
    logic                w_sat;
    logic                w_all_zero;
    logic [15:0]         w_dither;

`ifdef DEM_SWITCH_DITHER_EN
    logic [15:0] lfsr_q;
    logic        w_lfsr_fb;

    // Fibonacci taps 16,14,13,11
    assign w_lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign w_dither  = lfsr_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (clear_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (valid_i) begin
            lfsr_q <= {lfsr_q[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_dither = 16'h0000;
`endif

    // Input clip to [-NUM_OUT, +NUM_OUT]
    always_comb begin
        w_x_clip = x_in_i;
        w_sat    = 1'b0;
        if ($signed(x_in_i) > c_MAX) begin
            w_x_clip = c_MAX;
            w_sat    = 1'b1;
        end else if ($signed(x_in_i) < c_MIN) begin
            w_x_clip = c_MIN;
            w_sat    = 1'b1;
        end
    end

    // Stage enables, node inputs and the sat flag travelling with the sample
    always_comb begin
        w_en[1]     = valid_i & ~clear_i;
        w_sat_in[1] = w_sat;
        for (int n = 1; n <= NUM_LAYERS; n++) begin
            for (int i = 0; i < NUM_NODE; i++) begin
                w_node_in[n][i] = '0;
            end
        end
        w_node_in[1][0] = w_x_clip;
        for (int n = 2; n <= NUM_LAYERS; n++) begin
            w_en[n]     = valid_q[n-1];
            w_sat_in[n] = sat_q[n-1];
            for (int i = 0; i < NUM_NODE; i++) begin
                w_node_in[n][i] = stage_q[n-1][i];
            end
        end
    end

    // Switching nodes. Odd inputs get a +/-1 steer whose sign alternates per
    // node, so each node's running steering sum stays within one LSB.
    always_comb begin
        logic signed [W:0] xe;
        logic signed [W:0] s;
        logic signed [W:0] p;
        logic signed [W:0] m;
        logic              neg;
        stage_d = stage_q;
        tog_d   = tog_q;
        for (int n = 1; n <= NUM_LAYERS; n++) begin
            for (int i = 0; i < NUM_NODE; i++) begin
                if (i < (1 << (n - 1))) begin
                    xe  = {w_node_in[n][i][W-1], w_node_in[n][i]};
                    neg = tog_q[n][i] ^ w_dither[4'((n * 7 + i) % 16)];
                    s   = '0;
                    if (w_node_in[n][i][0]) begin
                        s           = neg ? {(W+1){1'b1}} : (W+1)'(1);
                        tog_d[n][i] = ~tog_q[n][i];
                    end
                    // x+s and x-s are even, so dropping bit 0 is exact
                    p = xe + s;
                    m = xe - s;
                    stage_d[n][2*i]   = p[W:1];
                    stage_d[n][2*i+1] = m[W:1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            sat_q   <= '0;
            cnt_q   <= '0;
            for (int n = 1; n <= NUM_LAYERS; n++) begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    stage_q[n][k] <= '0;
                end
                for (int i = 0; i < NUM_NODE; i++) begin
                    tog_q[n][i] <= 1'b0;
                end
            end
        end else if (clear_i) begin
            // In-flight samples are dropped; leaf data and count are kept
            valid_q <= '0;
            for (int n = 1; n <= NUM_LAYERS; n++) begin
                for (int i = 0; i < NUM_NODE; i++) begin
                    tog_q[n][i] <= 1'b0;
                end
            end
        end else begin
            valid_q <= w_en;
            for (int n = 1; n <= NUM_LAYERS; n++) begin
                if (w_en[n]) begin
                    sat_q[n] <= w_sat_in[n];
                    for (int k = 0; k < NUM_OUT; k++) begin
                        stage_q[n][k] <= stage_d[n][k];
                    end
                    for (int i = 0; i < NUM_NODE; i++) begin
                        tog_q[n][i] <= tog_d[n][i];
                    end
                end
            end
            // Counted on the load so the count includes the sample shown
            if (w_en[NUM_LAYERS]) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        w_all_zero = 1'b1;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (stage_q[NUM_LAYERS][k] != '0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign x_out_o[k*W +: W] = stage_q[NUM_LAYERS][k];
    end

    assign valid_o       = valid_q[NUM_LAYERS];
    assign layer_valid_o = valid_q;
    assign sat_o         = valid_q[NUM_LAYERS] & sat_q[NUM_LAYERS];
    assign zero_o        = valid_q[NUM_LAYERS] & w_all_zero;
    assign sample_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dem_switch_tree.sv
`default_nettype none
// ============================================================================
// Module   : tb_dem_switch_tree
// Purpose  : Self-checking bench for dem_switch_tree. A behavioural model
//            splits each accepted sample with integer arithmetic and queues
//            the expected leaf vector with its due edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dem_switch_tree;

    localparam int W       = 8;
    localparam int L       = 3;
    localparam int NUM_OUT = 2**L;
    localparam int MAXV    = NUM_OUT;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic                 clear_i;
    logic                 valid_i;
    logic [W-1:0]         x_in_i;
    logic                 valid_o;
    logic [NUM_OUT*W-1:0] x_out_o;
    logic [L-1:0]         layer_valid_o;
    logic                 sat_o;
    logic                 zero_o;
    logic [15:0]          sample_cnt_o;

    dem_switch_tree #(
        .INPUT_WIDTH (W),
        .NUM_LAYERS  (L),
        .LFSR_SEED   (16'hACE1)
    ) u_dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .valid_i       (valid_i),
        .x_in_i        (x_in_i),
        .valid_o       (valid_o),
        .x_out_o       (x_out_o),
        .layer_valid_o (layer_valid_o),
        .sat_o         (sat_o),
        .zero_o        (zero_o),
        .sample_cnt_o  (sample_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int                   due;
        logic [NUM_OUT*W-1:0] leaves;
        bit                   sat;
        int                   xc;
    } exp_t;

    exp_t                 q[$];
    int                   tg[1:L][0:NUM_OUT-1];
    int                   edge_n;
    int                   n_checks;
    int                   n_errors;
    logic [NUM_OUT*W-1:0] last_leaves;
    logic [15:0]          exp_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Split a clipped sample through the tree using the node rules directly
    function automatic logic [NUM_OUT*W-1:0] model_split(input int xc);
        int v[0:NUM_OUT-1];
        int nv[0:NUM_OUT-1];
        int s;
        logic [NUM_OUT*W-1:0] res;
        int lw;
        foreach (v[k]) v[k] = 0;
        v[0] = xc;
        for (int n = 1; n <= L; n++) begin
            foreach (nv[k]) nv[k] = 0;
            for (int i = 0; i < (1 << (n - 1)); i++) begin
                s = 0;
                if ((v[i] % 2) != 0) begin
                    s        = (tg[n][i] != 0) ? -1 : 1;
                    tg[n][i] = 1 - tg[n][i];
                end
                nv[2*i]   = (v[i] + s) / 2;
                nv[2*i+1] = (v[i] - s) / 2;
            end
            v = nv;
        end
        res = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            lw = v[k];
            res[k*W +: W] = lw[W-1:0];
        end
        return res;
    endfunction

    function automatic void model_reset_state();
        for (int n = 1; n <= L; n++)
            for (int i = 0; i < NUM_OUT; i++)
                tg[n][i] = 0;
        q.delete();
    endfunction

    task automatic check_outputs();
        logic       ev;
        logic [L-1:0] elv;
        exp_t       e;
        int         sum;
        int         bad;
        int         lf;
        ev  = (q.size() > 0) && (q[0].due == edge_n);
        elv = '0;
        foreach (q[j])
            for (int n = 1; n <= L; n++)
                if (q[j].due == edge_n + L - n) elv[n-1] = 1'b1;
        chk("valid_o", 64'(valid_o), 64'(ev));
        chk("layer_valid_o", 64'(layer_valid_o), 64'(elv));
        if (ev) begin
            e = q.pop_front();
            exp_cnt++;
            last_leaves = e.leaves;
            sum = 0;
            bad = 0;
            for (int k = 0; k < NUM_OUT; k++) begin
                lf  = $signed(x_out_o[k*W +: W]);
                sum += lf;
                if (lf < -1 || lf > 1) bad++;
            end
            chk("leaf_sum", 64'(sum), 64'(e.xc));
            chk("leaf_range", 64'(bad), 64'(0));
`ifndef DEM_SWITCH_DITHER_EN
            chk("x_out_o", 64'(x_out_o), 64'(e.leaves));
`endif
            chk("sat_o", 64'(sat_o), 64'(e.sat));
            chk("zero_o", 64'(zero_o), 64'(e.xc == 0));
        end else begin
`ifndef DEM_SWITCH_DITHER_EN
            chk("x_out_hold", 64'(x_out_o), 64'(last_leaves));
`endif
            chk("sat_o_idle", 64'(sat_o), 64'(0));
            chk("zero_o_idle", 64'(zero_o), 64'(0));
        end
        chk("sample_cnt_o", 64'(sample_cnt_o), 64'(exp_cnt));
    endtask

    // One clock: drive inputs, update the model at the edge, check after it
    task automatic step(input bit v, input int x, input bit clr);
        int   xc;
        exp_t e;
        valid_i = v;
        x_in_i  = 8'(x);
        clear_i = clr;
        @(posedge clk_i);
        edge_n++;
        if (clr) begin
            model_reset_state();
        end else if (v) begin
            xc       = (x > MAXV) ? MAXV : ((x < -MAXV) ? -MAXV : x);
            e.due    = edge_n + L - 1;
            e.xc     = xc;
            e.sat    = (xc != x);
            e.leaves = model_split(xc);
            q.push_back(e);
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        reset_i = 1'b1;
        valid_i = 1'b0;
        clear_i = 1'b0;
        #1;
        model_reset_state();
        last_leaves = '0;
        exp_cnt     = '0;
        chk("rst_valid_o", 64'(valid_o), 64'(0));
        chk("rst_x_out_o", 64'(x_out_o), 64'(0));
        chk("rst_layer_valid", 64'(layer_valid_o), 64'(0));
        chk("rst_cnt", 64'(sample_cnt_o), 64'(0));
        repeat (2) begin
            @(posedge clk_i);
            edge_n++;
        end
        #2;
        reset_i = 1'b0;
    endtask

    initial begin
        int x;
        n_checks    = 0;
        n_errors    = 0;
        edge_n      = 0;
        reset_i     = 1'b1;
        clear_i     = 1'b0;
        valid_i     = 1'b0;
        x_in_i      = '0;
        last_leaves = '0;
        exp_cnt     = '0;
        do_reset();

        // Single sample of 5, then drain
        step(1, 5, 0);
        step(0, 0, 0);
        step(0, 0, 0);
`ifndef DEM_SWITCH_DITHER_EN
        chk("t1_leaves", 64'(x_out_o), 64'h0001_0001_0001_0101);
`endif
        chk("t1_cnt", 64'(sample_cnt_o), 64'd1);
        step(0, 0, 0);

        // Back-to-back, clipping, zero, bubble pattern
        step(1, 5, 0);
        step(1, 5, 0);
        step(1, 20, 0);
        step(1, -20, 0);
        step(1, 0, 0);
        step(1, 3, 0);
        step(0, 0, 0);
        step(1, -3, 0);
        repeat (4) step(0, 0, 0);

        // Clear with two samples in flight, then a fresh sample
        step(1, 5, 0);
        step(1, 7, 0);
        step(1, 5, 1);
        repeat (4) step(0, 0, 0);
        step(1, 5, 0);
        repeat (2) step(0, 0, 0);
`ifndef DEM_SWITCH_DITHER_EN
        chk("post_clear_leaves", 64'(x_out_o), 64'h0001_0001_0001_0101);
`endif
        step(0, 0, 0);

        // Random stream with occasional out-of-range, clears and one reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                step(1, 1, 0);
                step(1, 2, 0);
                do_reset();
            end
            if ($urandom_range(0, 9) == 0)
                x = $signed(8'($urandom_range(0, 255)));
            else
                x = int'($urandom_range(0, 2 * MAXV)) - MAXV;
            step($urandom_range(0, 3) != 0, x, $urandom_range(0, 99) == 0);
        end
        repeat (L + 1) step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
